// File: rtl/mem_access_scheduler.sv
// Shares the banked RAM / SDRAM wrapper between the scalar CPU port and
// the 4-lane VPU port; one transaction in flight, VPU-first with CPU anti-starvation.
module mem_access_scheduler #(
  parameter logic [31:0] SDRAM_BASE     = 32'hC000_0000,
  parameter int          RD_LAT         = 1,
  parameter int          MAX_VPU_STREAK = 4,
  parameter int          SDRAM_TIMEOUT  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ack,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        vpu_req,
  input  logic        vpu_we,
  input  logic [31:0] vpu_addr0,
  input  logic [31:0] vpu_addr1,
  input  logic [31:0] vpu_addr2,
  input  logic [31:0] vpu_addr3,
  input  logic [31:0] vpu_wdata0,
  input  logic [31:0] vpu_wdata1,
  input  logic [31:0] vpu_wdata2,
  input  logic [31:0] vpu_wdata3,
  output logic        vpu_ack,
  output logic        vpu_rvalid,
  output logic [31:0] vpu_rdata0,
  output logic [31:0] vpu_rdata1,
  output logic [31:0] vpu_rdata2,
  output logic [31:0] vpu_rdata3,
  output logic        mem_sel,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_waitrequest,
  input  logic        sdram_readdatavalid,
  output logic        vpu_active,
  output logic        dm_v_write,
  output logic [31:0] data_addr0,
  output logic [31:0] data_addr1,
  output logic [31:0] data_addr2,
  output logic [31:0] data_addr3,
  output logic [31:0] v_store_data_0,
  output logic [31:0] v_store_data_1,
  output logic [31:0] v_store_data_2,
  output logic [31:0] v_store_data_3,
  input  logic [31:0] v_load_data_0,
  input  logic [31:0] v_load_data_1,
  input  logic [31:0] v_load_data_2,
  input  logic [31:0] v_load_data_3
);

  localparam int SW = $clog2(MAX_VPU_STREAK + 1);
  localparam int TW = $clog2(SDRAM_TIMEOUT + 1);
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE, CPU_ISSUE, VPU_ISSUE, RD_WAIT, SD_CMD, SD_RD
  } state_e;

  state_e             state_q;
  logic [SW-1:0]      streak_q;
  logic [TW-1:0]      tcnt_q;
  logic [2:0]         rcnt_q;
  logic               own_vpu_q;
  logic               cwe_q;
  logic [31:0]        caddr_q;
  logic [31:0]        cwdata_q;
  logic [3:0]         cwstrb_q;
  logic [31:0]        crdata_q;
  logic               vwe_q;
  logic [3:0][31:0]   vaddr_q;
  logic [3:0][31:0]   vwdata_q;
  logic [3:0][31:0]   vrdata_q;

  logic [3:0][31:0]   vaddr_in;
  logic [3:0][31:0]   vwdata_in;
  logic [3:0][31:0]   vld;
  logic               in_idle;
  logic               vpu_win;
  logic               cpu_win;
  logic               rd_last;
  logic               sd_hit;
  logic               sd_tmo;
  logic               cmd_st;

  assign vaddr_in  = {vpu_addr3, vpu_addr2, vpu_addr1, vpu_addr0};
  assign vwdata_in = {vpu_wdata3, vpu_wdata2, vpu_wdata1, vpu_wdata0};
  assign vld = {v_load_data_3, v_load_data_2, v_load_data_1, v_load_data_0};

  // The CPU only overrides the VPU once the streak limit is reached.
  assign in_idle = (state_q == IDLE);
  assign vpu_win = vpu_req &&
    !(cpu_req && (streak_q == SW'(MAX_VPU_STREAK)));
  assign cpu_win = cpu_req && !vpu_win;

  assign rd_last = (state_q == RD_WAIT) &&
    (rcnt_q == 3'(RD_LAT - 1));
  assign sd_hit = (state_q == SD_RD) && sdram_readdatavalid;
  assign sd_tmo = (state_q == SD_RD) && !sdram_readdatavalid &&
    (tcnt_q == TW'(SDRAM_TIMEOUT - 1));
  assign cmd_st = (state_q == CPU_ISSUE) || (state_q == SD_CMD);

  assign cpu_ack    = !reset && in_idle && cpu_win;
  assign vpu_ack    = !reset && in_idle && vpu_win;
  assign cpu_rvalid = !reset &&
    ((rd_last && !own_vpu_q) || sd_hit || sd_tmo);
  assign cpu_err    = !reset && sd_tmo;
  assign cpu_rdata  = !cpu_rvalid ? crdata_q :
    (sd_tmo ? ERR_WORD : mem_rdata);
  assign vpu_rvalid = !reset && rd_last && own_vpu_q;

  assign vpu_rdata0 = vpu_rvalid ? vld[0] : vrdata_q[0];
  assign vpu_rdata1 = vpu_rvalid ? vld[1] : vrdata_q[1];
  assign vpu_rdata2 = vpu_rvalid ? vld[2] : vrdata_q[2];
  assign vpu_rdata3 = vpu_rvalid ? vld[3] : vrdata_q[3];

  assign mem_sel = cmd_st || (state_q == SD_RD) ||
    ((state_q == RD_WAIT) && !own_vpu_q);
  assign mem_read   = cmd_st && !cwe_q;
  assign mem_write  = cmd_st && cwe_q;
  assign mem_addr   = caddr_q;
  assign mem_wdata  = cwdata_q;
  assign mem_wstrb  = cwstrb_q;

  assign vpu_active = (state_q == VPU_ISSUE) ||
    ((state_q == RD_WAIT) && own_vpu_q);
  assign dm_v_write = (state_q == VPU_ISSUE) && vwe_q;
  assign data_addr0 = vaddr_q[0];
  assign data_addr1 = vaddr_q[1];
  assign data_addr2 = vaddr_q[2];
  assign data_addr3 = vaddr_q[3];
  assign v_store_data_0 = vwdata_q[0];
  assign v_store_data_1 = vwdata_q[1];
  assign v_store_data_2 = vwdata_q[2];
  assign v_store_data_3 = vwdata_q[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      tcnt_q    <= '0;
      rcnt_q    <= '0;
      own_vpu_q <= 1'b0;
      cwe_q     <= 1'b0;
      caddr_q   <= '0;
      cwdata_q  <= '0;
      cwstrb_q  <= '0;
      crdata_q  <= '0;
      vwe_q     <= 1'b0;
      vaddr_q   <= '0;
      vwdata_q  <= '0;
      vrdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (vpu_win) begin
            own_vpu_q <= 1'b1;
            vwe_q     <= vpu_we;
            vaddr_q   <= vaddr_in;
            vwdata_q  <= vwdata_in;
            state_q   <= VPU_ISSUE;
            if (!cpu_req)
              streak_q <= '0;
            else if (streak_q != SW'(MAX_VPU_STREAK))
              streak_q <= streak_q + 1'b1;
          end else if (cpu_win) begin
            own_vpu_q <= 1'b0;
            cwe_q     <= cpu_we;
            caddr_q   <= cpu_addr;
            cwdata_q  <= cpu_wdata;
            cwstrb_q  <= cpu_wstrb;
            streak_q  <= '0;
            state_q   <= (cpu_addr >= SDRAM_BASE) ? SD_CMD : CPU_ISSUE;
          end
        end
        CPU_ISSUE: begin
          rcnt_q  <= '0;
          state_q <= cwe_q ? IDLE : RD_WAIT;
        end
        VPU_ISSUE: begin
          rcnt_q  <= '0;
          state_q <= vwe_q ? IDLE : RD_WAIT;
        end
        RD_WAIT: begin
          if (rd_last) begin
            if (own_vpu_q) vrdata_q <= vld;
            else           crdata_q <= mem_rdata;
            state_q <= IDLE;
          end else begin
            rcnt_q <= rcnt_q + 3'd1;
          end
        end
        SD_CMD: begin
          if (!mem_waitrequest) begin
            tcnt_q  <= '0;
            state_q <= cwe_q ? IDLE : SD_RD;
          end
        end
        SD_RD: begin
          if (sd_hit) begin
            crdata_q <= mem_rdata;
            state_q  <= IDLE;
          end else if (sd_tmo) begin
            crdata_q <= ERR_WORD;
            state_q  <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Directed bench for mem_access_scheduler with a small banked-RAM
// model behind the wrapper ports and bench-driven SDRAM handshakes.
module tb_mem_access_scheduler;

  logic clk = 1'b0;
  logic reset;
  logic cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0] cpu_wstrb;
  logic cpu_ack, cpu_rvalid, cpu_err;
  logic [31:0] cpu_rdata;
  logic vpu_req, vpu_we;
  logic [31:0] vpu_addr0, vpu_addr1, vpu_addr2, vpu_addr3;
  logic [31:0] vpu_wdata0, vpu_wdata1, vpu_wdata2, vpu_wdata3;
  logic vpu_ack, vpu_rvalid;
  logic [31:0] vpu_rdata0, vpu_rdata1, vpu_rdata2, vpu_rdata3;
  logic mem_sel, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  logic mem_waitrequest, sdram_readdatavalid;
  logic vpu_active, dm_v_write;
  logic [31:0] data_addr0, data_addr1, data_addr2, data_addr3;
  logic [31:0] v_store_data_0, v_store_data_1;
  logic [31:0] v_store_data_2, v_store_data_3;
  logic [31:0] v_load_data_0, v_load_data_1;
  logic [31:0] v_load_data_2, v_load_data_3;

  always #5 clk = ~clk;

  mem_access_scheduler #(
    .SDRAM_BASE(32'hC000_0000), .RD_LAT(1),
    .MAX_VPU_STREAK(4), .SDRAM_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .vpu_req(vpu_req), .vpu_we(vpu_we),
    .vpu_addr0(vpu_addr0), .vpu_addr1(vpu_addr1),
    .vpu_addr2(vpu_addr2), .vpu_addr3(vpu_addr3),
    .vpu_wdata0(vpu_wdata0), .vpu_wdata1(vpu_wdata1),
    .vpu_wdata2(vpu_wdata2), .vpu_wdata3(vpu_wdata3),
    .vpu_ack(vpu_ack), .vpu_rvalid(vpu_rvalid),
    .vpu_rdata0(vpu_rdata0), .vpu_rdata1(vpu_rdata1),
    .vpu_rdata2(vpu_rdata2), .vpu_rdata3(vpu_rdata3),
    .mem_sel(mem_sel), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_waitrequest(mem_waitrequest),
    .sdram_readdatavalid(sdram_readdatavalid),
    .vpu_active(vpu_active), .dm_v_write(dm_v_write),
    .data_addr0(data_addr0), .data_addr1(data_addr1),
    .data_addr2(data_addr2), .data_addr3(data_addr3),
    .v_store_data_0(v_store_data_0), .v_store_data_1(v_store_data_1),
    .v_store_data_2(v_store_data_2), .v_store_data_3(v_store_data_3),
    .v_load_data_0(v_load_data_0), .v_load_data_1(v_load_data_1),
    .v_load_data_2(v_load_data_2), .v_load_data_3(v_load_data_3)
  );

  // Banked RAM: CPU byte address -> bank addr[3:2], row addr[11:4].
  logic [31:0] bank [4][256];
  logic [31:0] ram_q;
  logic [31:0] ld_q [4];
  logic [31:0] da [4];
  logic [31:0] vsd [4];
  logic sd_mode;
  logic [31:0] sd_data;

  assign da[0] = data_addr0;
  assign da[1] = data_addr1;
  assign da[2] = data_addr2;
  assign da[3] = data_addr3;
  assign vsd[0] = v_store_data_0;
  assign vsd[1] = v_store_data_1;
  assign vsd[2] = v_store_data_2;
  assign vsd[3] = v_store_data_3;
  assign mem_rdata = sd_mode ? sd_data : ram_q;
  assign v_load_data_0 = ld_q[0];
  assign v_load_data_1 = ld_q[1];
  assign v_load_data_2 = ld_q[2];
  assign v_load_data_3 = ld_q[3];

  always @(posedge clk) begin
    ram_q <= bank[mem_addr[3:2]][mem_addr[11:4]];
    for (int n = 0; n < 4; n++)
      ld_q[n] <= bank[n][da[n][7:0]];
    if (mem_sel && mem_write && mem_addr < 32'hC000_0000)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b])
          bank[mem_addr[3:2]][mem_addr[11:4]][8*b +: 8]
            <= mem_wdata[8*b +: 8];
    if (vpu_active && dm_v_write)
      for (int n = 0; n < 4; n++)
        bank[n][da[n][7:0]] <= vsd[n];
  end

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_txn(input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output logic ok);
    logic acked;
    ok = 1'b0;
    rd = '0;
    tick();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a;
    cpu_wdata = d; cpu_wstrb = s;
    @(negedge clk);
    acked = cpu_ack;
    tick();
    cpu_req = 1'b0;
    if (acked && we) ok = 1'b1;
    if (acked && !we)
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (cpu_rvalid) begin
          rd = cpu_rdata;
          ok = 1'b1;
          break;
        end
        tick();
      end
  endtask

  task automatic check_quiet(input string nm);
    check({nm, "_ctl"},
      {22'd0, cpu_ack, cpu_rvalid, cpu_err, vpu_ack, vpu_rvalid,
       mem_sel, mem_read, mem_write, vpu_active, dm_v_write}, 32'd0);
    check({nm, "_dat"},
      mem_addr | mem_wdata | {28'd0, mem_wstrb} | cpu_rdata |
      data_addr0 | data_addr3 | v_store_data_0 | v_store_data_3 |
      vpu_rdata0 | vpu_rdata3, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];
  logic [31:0] rd;
  logic ok;
  logic [9:0] exp_seq;
  int g, nrd, nrv, rvk;
  logic [31:0] got;
  logic gerr;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 32'h104, 32'h1122_3344, 4'hF, 32'h0};
    tbl[1] = '{1'b0, 32'h104, 32'h0, 4'h0, 32'h1122_3344};
    tbl[2] = '{1'b1, 32'h104, 32'hAABB_CCDD, 4'b0101, 32'h0};
    tbl[3] = '{1'b0, 32'h104, 32'h0, 4'h0, 32'h11BB_33DD};
    tbl[4] = '{1'b1, 32'h104, 32'hFFFF_FFFF, 4'h0, 32'h0};
    tbl[5] = '{1'b0, 32'h104, 32'h0, 4'h0, 32'h11BB_33DD};
    tbl[6] = '{1'b1, 32'h200, 32'hCAFE_F00D, 4'hF, 32'h0};
    tbl[7] = '{1'b0, 32'h200, 32'h0, 4'h0, 32'hCAFE_F00D};

    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
    vpu_req = 0; vpu_we = 0;
    vpu_addr0 = 0; vpu_addr1 = 0; vpu_addr2 = 0; vpu_addr3 = 0;
    vpu_wdata0 = 0; vpu_wdata1 = 0; vpu_wdata2 = 0; vpu_wdata3 = 0;
    mem_waitrequest = 0; sdram_readdatavalid = 0;
    sd_mode = 0; sd_data = 0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check_quiet("reset");

    for (int i = 0; i < 8; i++) begin
      cpu_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, ok);
      check($sformatf("tbl%0d_done", i), {31'd0, ok}, 32'd1);
      if (!tbl[i].we)
        check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
    end

    // Cycle-exact on-chip read at 0x104.
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h104;
    @(negedge clk);
    check("rd_c0_ack", {31'd0, cpu_ack}, 32'd1);
    tick();
    cpu_req = 0;
    @(negedge clk);
    check("rd_c1_read", {30'd0, mem_read, cpu_rvalid}, 32'd2);
    check("rd_c1_addr", mem_addr, 32'h104);
    tick();
    @(negedge clk);
    check("rd_c2_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check("rd_c2_rdata", cpu_rdata, 32'h11BB_33DD);
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h300; cpu_wstrb = 0;
    @(negedge clk);
    check("rd_c3_idle", {31'd0, cpu_ack}, 32'd1);
    tick();
    cpu_req = 0;

    // VPU store then load of the same lanes.
    tick();
    vpu_req = 1; vpu_we = 1;
    vpu_addr0 = 0; vpu_addr1 = 1; vpu_addr2 = 2; vpu_addr3 = 3;
    vpu_wdata0 = 32'hA; vpu_wdata1 = 32'hB;
    vpu_wdata2 = 32'hC; vpu_wdata3 = 32'hD;
    @(negedge clk);
    check("vst_ack", {31'd0, vpu_ack}, 32'd1);
    tick();
    vpu_req = 0;
    @(negedge clk);
    check("vst_ctl", {29'd0, vpu_active, dm_v_write, vpu_rvalid}, 32'd6);
    check("vst_addr", {data_addr3[7:0], data_addr2[7:0],
      data_addr1[7:0], data_addr0[7:0]}, 32'h0302_0100);
    check("vst_data", {v_store_data_3[7:0], v_store_data_2[7:0],
      v_store_data_1[7:0], v_store_data_0[7:0]}, 32'h0D0C_0B0A);
    tick();
    @(negedge clk);
    check("vst_after", {30'd0, vpu_active, vpu_rvalid}, 32'd0);
    tick();
    vpu_req = 1; vpu_we = 0;
    @(negedge clk);
    check("vld_ack", {31'd0, vpu_ack}, 32'd1);
    tick();
    vpu_req = 0;
    @(negedge clk);
    check("vld_issue", {30'd0, vpu_active, dm_v_write}, 32'd2);
    tick();
    @(negedge clk);
    check("vld_rvalid", {31'd0, vpu_rvalid}, 32'd1);
    check("vld_rdata0", vpu_rdata0, 32'hA);
    check("vld_rdata1", vpu_rdata1, 32'hB);
    check("vld_rdata2", vpu_rdata2, 32'hC);
    check("vld_rdata3", vpu_rdata3, 32'hD);

    // Both requesters held: four VPU grants, then one CPU grant.
    exp_seq = 10'b01111_01111;
    g = 0;
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h300; cpu_wstrb = 0;
    vpu_req = 1; vpu_we = 1;
    vpu_addr0 = 20; vpu_addr1 = 21; vpu_addr2 = 22; vpu_addr3 = 23;
    for (int c = 0; c < 60 && g < 10; c++) begin
      @(negedge clk);
      if (cpu_ack || vpu_ack) begin
        check($sformatf("grant%0d", g),
          {30'd0, vpu_ack, cpu_ack}, exp_seq[g] ? 32'd2 : 32'd1);
        g++;
      end
      tick();
    end
    check("grant_count", g, 10);
    cpu_req = 0; vpu_req = 0;
    repeat (3) tick();

    // SDRAM read: 3 wait cycles, data 5 cycles after acceptance.
    sd_mode = 1; mem_waitrequest = 1;
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'hC000_0010;
    @(negedge clk);
    check("sd_ack", {31'd0, cpu_ack}, 32'd1);
    nrd = 0; nrv = 0; rvk = -1; got = 0; gerr = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      cpu_req = 0;
      mem_waitrequest = (k < 3);
      sdram_readdatavalid = (k == 8);
      sd_data = (k == 8) ? 32'h5A5A_0001 : 32'h0;
      @(negedge clk);
      if (mem_sel && mem_read) nrd++;
      if (cpu_rvalid) begin
        nrv++; rvk = k; got = cpu_rdata; gerr = cpu_err;
      end
    end
    check("sd_read_cycles", nrd, 4);
    check("sd_rvalid_count", nrv, 1);
    check("sd_rvalid_cycle", rvk, 8);
    check("sd_rdata", got, 32'h5A5A_0001);
    check("sd_err", {31'd0, gerr}, 32'd0);
    check("sd_addr", mem_addr, 32'hC000_0010);

    // SDRAM read that never returns, then a stray readdatavalid.
    tick();
    mem_waitrequest = 0; sdram_readdatavalid = 0; sd_data = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'hC000_0020;
    @(negedge clk);
    check("to_ack", {31'd0, cpu_ack}, 32'd1);
    nrv = 0; rvk = -1; got = 0; gerr = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      cpu_req = 0;
      sdram_readdatavalid = (k == 12);
      @(negedge clk);
      if (cpu_rvalid) begin
        nrv++; rvk = k; got = cpu_rdata; gerr = cpu_err;
      end
    end
    check("to_rvalid_count", nrv, 1);
    check("to_rvalid_cycle", rvk, 8);
    check("to_err", {31'd0, gerr}, 32'd1);
    check("to_rdata", got, 32'hDEAD_BEEF);
    sdram_readdatavalid = 0;
    sd_mode = 0;
    cpu_txn(1'b0, 32'h104, 32'h0, 4'h0, rd, ok);
    check("to_after_done", {31'd0, ok}, 32'd1);
    check("to_after_rdata", rd, 32'h11BB_33DD);

    // Reset during RD_WAIT of a VPU load.
    tick();
    vpu_req = 1; vpu_we = 0;
    vpu_addr0 = 0; vpu_addr1 = 1; vpu_addr2 = 2; vpu_addr3 = 3;
    @(negedge clk);
    check("rst_vack", {31'd0, vpu_ack}, 32'd1);
    tick();
    vpu_req = 0;
    tick();
    reset = 1;
    @(negedge clk);
    check("rst_no_rvalid", {31'd0, vpu_rvalid}, 32'd0);
    tick();
    reset = 0;
    @(negedge clk);
    check_quiet("rst_after");
    cpu_txn(1'b0, 32'h104, 32'h0, 4'h0, rd, ok);
    check("rst_new_done", {31'd0, ok}, 32'd1);
    check("rst_new_rdata", rd, 32'h11BB_33DD);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
